// File: rtl/matrix_ctrl_pkg.sv
// Shared definitions for the 2x2 matrix reconfigurable-module controller.
// A matrix is four ELEM_W-bit elements packed MSB-first: [0][0],[0][1],[1][0],[1][1].
package matrix_ctrl_pkg;

  localparam int ELEM_W  = 8;
  localparam int MAT_DIM = 2;
  localparam int MAT_W   = MAT_DIM * MAT_DIM * ELEM_W;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT      = 2'd1;
  localparam logic [1:0] RESP      = 2'd2;
  localparam logic [1:0] DECOUPLED = 2'd3;

  typedef logic [MAT_W-1:0] mat_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; grant is combinational, history advances
// only when the caller reports a completed transfer through update_i.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);

  logic last_q;
  logic last_d;

  // On contention the requester that did not win last time gets the slot.
  always_comb begin
    gnt_id_o = req_i[1];
    if (req_i == 2'b11) begin
      gnt_id_o = ~last_q;
    end
  end

  assign gnt_valid_o = |req_i;

  always_comb begin
    last_d = last_q;
    if (update_i) begin
      last_d = gnt_id_o;
    end
  end

  // Reset to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/matrix_rm_controller.sv
// Sequencer/arbiter for the reconfigurable 2x2 matrix module: grants one of two
// requesters, waits RM_LATENCY cycles, returns the result and supports PR decoupling.
module matrix_rm_controller
  import matrix_ctrl_pkg::*;
#(
  parameter int RM_LATENCY = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [MAT_W-1:0] req0_a,
  input  logic [MAT_W-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [MAT_W-1:0] req1_a,
  input  logic [MAT_W-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [MAT_W-1:0] rsp_res,
  output logic             rsp_id,
  output logic [MAT_W-1:0] rm_a,
  output logic [MAT_W-1:0] rm_b,
  input  logic [MAT_W-1:0] rm_res,
  input  logic             pr_req,
  output logic             pr_ack,
  output logic             busy,
  output logic [CNT_W-1:0] done_count
);

  localparam logic [3:0] CNT_INIT = 4'(RM_LATENCY);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  mat_t             rm_a_q, rm_a_d;
  mat_t             rm_b_q, rm_b_d;
  mat_t             rsp_res_q, rsp_res_d;
  logic             rsp_id_q, rsp_id_d;
  logic [CNT_W-1:0] done_q, done_d;

  logic       gnt_valid;
  logic       gnt_id;
  logic       accept_ok;
  logic [1:0] ready_vec;
  logic       fire;

  rr_arbiter2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .req_i      ({req1_valid, req0_valid}),
    .update_i   (fire),
    .gnt_valid_o(gnt_valid),
    .gnt_id_o   (gnt_id)
  );

  assign accept_ok = (state_q == IDLE) && !pr_req && !rst;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign ready_vec[gi] = accept_ok && gnt_valid && (gnt_id == 1'(gi));
    end
  endgenerate

  assign fire       = |ready_vec;
  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rm_a_d    = rm_a_q;
    rm_b_d    = rm_b_q;
    rsp_res_d = rsp_res_q;
    rsp_id_d  = rsp_id_q;
    done_d    = done_q;
    case (state_q)
      IDLE: begin
        if (pr_req) begin
          state_d = DECOUPLED;
          rm_a_d  = '0;
          rm_b_d  = '0;
        end else if (fire) begin
          state_d  = WAIT;
          cnt_d    = CNT_INIT;
          rm_a_d   = gnt_id ? req1_a : req0_a;
          rm_b_d   = gnt_id ? req1_b : req0_b;
          rsp_id_d = gnt_id;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          rsp_res_d = rm_res;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          done_d = done_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (pr_req) begin
            state_d = DECOUPLED;
            rm_a_d  = '0;
            rm_b_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DECOUPLED: begin
        if (!pr_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rm_a_q    <= '0;
      rm_b_q    <= '0;
      rsp_res_q <= '0;
      rsp_id_q  <= 1'b0;
      done_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rm_a_q    <= rm_a_d;
      rm_b_q    <= rm_b_d;
      rsp_res_q <= rsp_res_d;
      rsp_id_q  <= rsp_id_d;
      done_q    <= done_d;
    end
  end

  assign rsp_valid  = (state_q == RESP);
  assign busy       = (state_q == WAIT) || (state_q == RESP);
  assign pr_ack     = (state_q == DECOUPLED);
  assign rsp_res    = rsp_res_q;
  assign rsp_id     = rsp_id_q;
  assign rm_a       = rm_a_q;
  assign rm_b       = rm_b_q;
  assign done_count = done_q;

endmodule

// File: tb/tb_matrix_rm_controller.sv
// Scoreboard bench for matrix_rm_controller with an element-wise adder as the
// attached reconfigurable module.
`timescale 1ns/1ps
module tb_matrix_rm_controller;

  localparam int LAT = 4;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [31:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [31:0]   rsp_res;
  logic          rsp_id;
  logic [31:0]   rm_a, rm_b, rm_res;
  logic          pr_req = 1'b0;
  logic          pr_ack, busy;
  logic [CW-1:0] done_count;

  always #5 clk = ~clk;

  matrix_rm_controller #(.RM_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_id(rsp_id),
    .rm_a(rm_a), .rm_b(rm_b), .rm_res(rm_res),
    .pr_req(pr_req), .pr_ack(pr_ack), .busy(busy), .done_count(done_count)
  );

  // Element-wise 2x2 matrix sum, each element modulo 256.
  function automatic logic [31:0] madd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    for (int e = 0; e < 4; e++) r[e*8 +: 8] = a[e*8 +: 8] + b[e*8 +: 8];
    return r;
  endfunction

  assign rm_res = madd(rm_a, rm_b);

  typedef struct {
    logic [31:0] res;
    logic        id;
    int          t;
  } exp_t;

  exp_t          sbq[$];
  int            acc_ids[$];
  int            vec = 0, errs = 0;
  int            cyc = 0;
  logic          rst_at_edge = 1'b0;
  logic [CW-1:0] exp_done = '0;
  logic          last_id = 1'b1;
  logic          valid_prev = 1'b0, stall_prev = 1'b0;
  bit            rand_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  // Monitor: arbitration rules, response scoreboard, decoupled outputs, reset values.
  always @(negedge clk) begin : monitor
    logic want;
    if (rst) begin
      chk("rst_ready", {req1_ready, req0_ready}, 0);
      if (rst_at_edge) begin
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_res", rsp_res, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rm_a", rm_a, 0);
        chk("rst_rm_b", rm_b, 0);
        chk("rst_pr_ack", pr_ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done_count, 0);
      end
      sbq.delete();
      exp_done   = '0;
      last_id    = 1'b1;
      valid_prev = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (req0_ready || req1_ready) begin
        chk("ready_legal", {req0_ready && req1_ready, pr_req, busy, rsp_valid, pr_ack}, 0);
        if (req0_valid || req1_valid) begin
          want = (req0_valid && req1_valid) ? ~last_id : req1_valid;
          chk("grant", req1_ready, want);
          last_id = req1_ready;
          acc_ids.push_back(int'(req1_ready));
        end
      end
      if (stall_prev) chk("rsp_hold_valid", rsp_valid, 1);
      if (rsp_valid) begin
        if (sbq.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 0);
        end else begin
          chk("rsp_res", rsp_res, sbq[0].res);
          chk("rsp_id", rsp_id, sbq[0].id);
          chk("busy_resp", busy, 1);
          if (!valid_prev) chk("latency", cyc - sbq[0].t, LAT);
          if (rsp_ready) begin
            chk("done_count", done_count, exp_done);
            $display("txn id=%0d res=%h done=%0d", rsp_id, rsp_res, done_count);
            exp_done++;
            void'(sbq.pop_front());
          end
        end
      end
      if (pr_ack) begin
        chk("dec_rm_a", rm_a, 0);
        chk("dec_rm_b", rm_b, 0);
        chk("dec_busy", busy, 0);
      end
      valid_prev = rsp_valid;
      stall_prev = rsp_valid && !rsp_ready;
    end
  end

  // Present one operand pair on requester n until accepted; record expectation.
  task automatic send(input int n, input logic [31:0] a, input logic [31:0] b);
    int  k;
    logic rdy;
    if (n == 0) begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
    else        begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      rdy = (n == 0) ? req0_ready : req1_ready;
      if (!rst && rdy) break;
    end
    if (k == 300) begin
      vec++;
      errs++;
      $display("FAIL send_timeout req%0d: no ready in %0d cycles, ready required", n, k);
    end else begin
      sbq.push_back('{madd(a, b), n[0], cyc + 1});
    end
    @(posedge clk);
    #1;
    if (n == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 300 && (sbq.size() != 0 || busy); k++) tick();
    if (k == 300) begin
      vec++;
      errs++;
      $display("FAIL idle_timeout: still busy after %0d cycles, idle required", k);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready) rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) tick();
    rst = 1'b0;

    // Basic add and element wrap.
    send(0, 32'h01020304, 32'h10203040);
    wait_idle();
    chk("first_res", rsp_res, 32'h11223344);
    chk("first_done", done_count, 1);
    send(0, 32'hFF800001, 32'h01800001);
    wait_idle();
    chk("wrap_res", rsp_res, 32'h00000002);

    // Continuous contention: grants must alternate.
    acc_ids.delete();
    fork
      begin send(0, $urandom, $urandom); send(0, $urandom, $urandom); end
      begin send(1, $urandom, $urandom); send(1, $urandom, $urandom); end
    join
    wait_idle();
    chk("alt_count", acc_ids.size(), 4);
    for (int i = 1; i < acc_ids.size(); i++) chk("alternate", acc_ids[i], 1 - acc_ids[i-1]);

    // Randomized traffic with random backpressure.
    rand_ready = 1'b1;
    fork
      for (int i = 0; i < 15; i++) begin
        repeat ($urandom_range(0, 3)) tick();
        send(0, $urandom, $urandom);
      end
      for (int i = 0; i < 15; i++) begin
        repeat ($urandom_range(0, 3)) tick();
        send(1, $urandom, $urandom);
      end
    join
    tick();
    rand_ready = 1'b0;
    rsp_ready  = 1'b1;
    wait_idle();
    chk("rand_done", done_count, exp_done);

    // Backpressure for 5 cycles in RESP with a competing request pending.
    rsp_ready = 1'b0;
    fork
      send(0, 32'hFFFFFFFF, 32'h01010101);
      begin repeat (2) tick(); send(1, 32'h11111111, 32'h22222222); end
      begin
        for (int j = 0; j < 50 && !rsp_valid; j++) tick();
        chk("bp_valid", rsp_valid, 1);
        repeat (5) begin
          tick();
          chk("bp_hold", rsp_valid, 1);
          chk("bp_done", done_count, exp_done);
        end
        rsp_ready = 1'b1;
      end
    join
    wait_idle();
    chk("bp_done_after", done_count, exp_done);

    // Quiesce request raised mid-WAIT.
    send(0, $urandom, $urandom);
    tick();
    pr_req = 1'b1;
    fork
      send(1, 32'h0A0B0C0D, 32'h01010101);
      begin
        for (k = 0; k < 100 && !pr_ack; k++) tick();
        chk("pr_ack_rise", pr_ack, 1);
        chk("pr_rm_a", rm_a, 0);
        chk("pr_rm_b", rm_b, 0);
        chk("pr_done", done_count, exp_done);
        repeat (4) tick();
        chk("pr_ack_hold", pr_ack, 1);
        pr_req = 1'b0;
        tick();
        chk("pr_ack_fall", pr_ack, 0);
      end
    join
    wait_idle();

    // Quiesce request while IDLE.
    pr_req = 1'b1;
    tick();
    chk("idle_pr_ack", pr_ack, 1);
    chk("idle_pr_rm_a", rm_a, 0);
    pr_req = 1'b0;
    tick();
    chk("idle_pr_ack_fall", pr_ack, 0);

    // Reset mid-WAIT drops the operation; req0 wins the next contention.
    send(1, $urandom, $urandom);
    tick();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("post_rst_valid", rsp_valid, 0);
    chk("post_rst_busy", busy, 0);
    acc_ids.delete();
    fork
      send(1, $urandom, $urandom);
      send(0, $urandom, $urandom);
    join
    wait_idle();
    if (acc_ids.size() > 0) chk("post_rst_grant", acc_ids[0], 0);
    chk("post_rst_done", done_count, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
